// File: rtl/demux1_8_stream_if.sv
// Bundle of the producer stream and the eight consumer lanes around demux1_8_stream.
// Handshake: a word moves on a rising edge where valid & ready are both high; valid never depends on ready.
interface demux1_8_stream_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic [8*WIDTH-1:0] out_data;
  logic             idle;

  // Demux side
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, idle
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, idle
  );
endinterface

// File: rtl/demux1_8_stream.sv
// Registered 1-to-8 stream demultiplexer: each lane owns a one-entry buffer, so a
// stalled lane only blocks words addressed to it.
`ifndef ARCH_WIDTH
`define ARCH_WIDTH 64
`endif

module demux1_8_stream #(
  parameter int WIDTH = `ARCH_WIDTH
) (
  input  logic clk,
  input  logic rst,
  demux1_8_stream_if.slave bus
);
  localparam int LANES = 8;

  logic [LANES-1:0] full;
  logic [WIDTH-1:0] lane_buf [LANES];
  logic             accept;
  logic [LANES-1:0] acc_mask;

  // Readiness looks only at the addressed lane; a drain this edge frees the slot.
  assign bus.in_ready = ~full[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    acc_mask = '0;
    if (accept) acc_mask[bus.in_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      for (int i = 0; i < LANES; i++) lane_buf[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (acc_mask[i]) begin
          lane_buf[i] <= bus.in_data;
          full[i]     <= 1'b1;
        end else if (bus.out_ready[i]) begin
          full[i]     <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = full;
  assign bus.idle      = ~|full;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign bus.out_data[g*WIDTH +: WIDTH] = lane_buf[g];
  end
endmodule

// File: tb/tb_demux1_8_stream.sv
// Directed bench for demux1_8_stream: reset, routing, backpressure, isolation,
// streaming and idle behaviour against hand-computed expectations.
module tb_demux1_8_stream;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  logic [W-1:0] exp_q [$];

  demux1_8_stream_if #(.WIDTH(W)) bus ();

  demux1_8_stream #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  function automatic logic [W-1:0] lane(input int i);
    return bus.out_data[i*W +: W];
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [W-1:0] data);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = data;
  endtask

  initial begin
    logic [W-1:0] got_w;
    drive(1'b0, 3'd0, '0);
    bus.out_ready = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_out_valid", W'(bus.out_valid), 64'h0);
    check("rst_idle",      W'(bus.idle),      64'h1);
    check("rst_in_ready",  W'(bus.in_ready),  64'h1);
    check("rst_data0",     lane(0),           64'h0);

    // Fill lanes 2 and 5, then reset mid-cycle
    drive(1'b1, 3'd2, 64'h22); tick();
    drive(1'b1, 3'd5, 64'h55); tick();
    drive(1'b0, 3'd5, 64'h0);
    check("fill_out_valid", W'(bus.out_valid), 64'h24);
    check("fill_idle",      W'(bus.idle),      64'h0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", W'(bus.out_valid), 64'h0);
    check("async_rst_idle",      W'(bus.idle),      64'h1);
    check("async_rst_in_ready",  W'(bus.in_ready),  64'h1);
    check("async_rst_data5",     lane(5),           64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 3'd0, 64'h77);
    tick();
    drive(1'b0, 3'd0, 64'h0);
    check("first_accept_valid", W'(bus.out_valid), 64'h1);
    check("first_accept_data",  lane(0),           64'h77);
    bus.out_ready = 8'hFF;
    tick();
    check("first_drain", W'(bus.out_valid), 64'h0);

    // Routing sweep
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 3'(s), 64'h1000 + W'(s));
      #1;
      check($sformatf("sweep_ready%0d", s), W'(bus.in_ready), 64'h1);
      tick();
      check($sformatf("sweep_valid%0d", s), W'(bus.out_valid), W'(8'h01 << s));
      check($sformatf("sweep_data%0d", s),  lane(s),           64'h1000 + W'(s));
    end
    drive(1'b0, 3'd0, 64'h0);
    tick();
    check("sweep_empty", W'(bus.out_valid), 64'h0);

    // Backpressure on lane 3
    bus.out_ready = 8'hF7;
    drive(1'b1, 3'd3, 64'hAAAA); tick();
    check("bp_first_valid", W'(bus.out_valid), 64'h08);
    check("bp_first_data",  lane(3),           64'hAAAA);
    drive(1'b1, 3'd3, 64'hBBBB);
    #1;
    check("bp_stall_ready", W'(bus.in_ready), 64'h0);
    tick();
    check("bp_hold_data",  lane(3),           64'hAAAA);
    check("bp_hold_valid", W'(bus.out_valid), 64'h08);
    bus.out_ready = 8'hFF;
    #1;
    check("bp_release_ready", W'(bus.in_ready), 64'h1);
    check("bp_drain_data",    lane(3),          64'hAAAA);
    tick();
    check("bp_second_valid", W'(bus.out_valid), 64'h08);
    check("bp_second_data",  lane(3),           64'hBBBB);
    drive(1'b0, 3'd0, 64'h0);
    tick();
    check("bp_empty", W'(bus.out_valid), 64'h0);

    // Isolation: lane 3 stalled, lane 6 still accepts
    bus.out_ready = 8'h00;
    drive(1'b1, 3'd3, 64'h3333); tick();
    drive(1'b1, 3'd6, 64'hCCCC);
    #1;
    check("iso_ready", W'(bus.in_ready), 64'h1);
    tick();
    drive(1'b0, 3'd0, 64'h0);
    check("iso_valid", W'(bus.out_valid), 64'h48);
    check("iso_data6", lane(6),           64'hCCCC);
    check("iso_data3", lane(3),           64'h3333);
    bus.out_ready = 8'hFF;
    tick();
    check("iso_empty", W'(bus.out_valid), 64'h0);

    // Streaming on lane 1, scoreboarded through exp_q
    for (int w = 0; w < 16; w++) begin
      drive(1'b1, 3'd1, W'(w));
      exp_q.push_back(W'(w));
      #1;
      check($sformatf("stream_ready%0d", w), W'(bus.in_ready), 64'h1);
      tick();
      check($sformatf("stream_valid%0d", w), W'(bus.out_valid), 64'h02);
      got_w = lane(1);
      check($sformatf("stream_data%0d", w), got_w, exp_q.pop_front());
    end
    drive(1'b0, 3'd0, 64'h0);
    tick();
    check("stream_empty", W'(bus.out_valid), 64'h0);
    check("stream_q_empty", W'(exp_q.size()), 64'h0);

    // Idle tracking
    bus.out_ready = 8'h00;
    drive(1'b1, 3'd0, 64'hA0); tick();
    drive(1'b1, 3'd7, 64'hA7); tick();
    drive(1'b0, 3'd0, 64'h0);
    check("idle_busy",       W'(bus.idle),      64'h0);
    check("idle_fill_valid", W'(bus.out_valid), 64'h81);
    bus.out_ready = 8'h01;
    tick();
    check("idle_after_first",  W'(bus.idle),      64'h0);
    check("idle_first_valid",  W'(bus.out_valid), 64'h80);
    check("idle_lane7_data",   lane(7),           64'hA7);
    bus.out_ready = 8'h80;
    tick();
    check("idle_after_second", W'(bus.idle),      64'h1);
    check("idle_final_valid",  W'(bus.out_valid), 64'h0);

    // Final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/demux1_8_stream.md
Name: demux1_8_stream

Overview:
- Registered 1-to-8 stream demultiplexer with a valid/ready handshake.
- Performs the write-side inverse of the 8:1 operand select. One producer stream of ARCH_WIDTH words is steered by a 3-bit select to one of eight consumer lanes.
- Each lane has a one-entry output buffer, so a stalled lane blocks only traffic addressed to it.
- Used where a single result source (e.g. writeback or a decode stage) fans out to up to eight sinks.

Parameters:
- WIDTH, default `ARCH_WIDTH (64): data word width.
- LANES, fixed 8: number of output lanes. Not overridable; the select is 3 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  producer word valid.
- in_ready  output  1  demux can accept the word on in_sel this cycle.
- in_sel  input  3  destination lane; must be stable while in_valid is high and in_ready is low.
- in_data  input  WIDTH  producer word.
- out_valid  output  8  bit i: lane i buffer holds a word.
- out_ready  input  8  bit i: consumer i accepts.
- out_data  output  8*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- idle  output  1  all eight lane buffers empty.

Behaviour:
- Clock and reset: one clock domain; rst is asynchronous, active-high.
- Per-lane state: full[i] (1 bit) and buf[i] (WIDTH bits). out_valid[i] = full[i]; out_data lane i = buf[i].
- Reset: all full[i] = 0 and all buf[i] = 0, so out_valid = 8'h00, out_data = 0, idle = 1, in_ready = 1.
  - Assertion takes effect immediately, without waiting for a clock edge.
  - Buffered words are discarded; reset mid-transfer loses them silently.
  - First accept is possible on the first rising edge after rst deasserts.
- in_ready (combinational) = ~full[in_sel] | out_ready[in_sel].
  - It depends only on the addressed lane, never on in_valid.
- Accept: in_valid & in_ready at a rising edge.
  - buf[in_sel] <= in_data; full[in_sel] <= 1.
- Drain: full[i] & out_ready[i] at a rising edge.
  - full[i] <= 0, unless the same lane is accepted in that cycle.
- Simultaneous drain and accept on the same lane: full stays 1 and buf takes the new word. Full throughput of one word per cycle per lane.
- Accept on lane j with a drain on lane k≠j in the same cycle: both take effect independently.
- Latency: a word accepted at edge N is visible on out_valid/out_data after edge N (one-cycle latency).
  - No combinational path from in_valid or in_data to any out_* port.
- Hold: while full[i] & ~out_ready[i], buf[i] and out_valid[i] are stable.
  - out_valid[i] never drops without a handshake, except on reset.
- Ordering: order is preserved within a lane. No ordering is guaranteed across lanes.
- Stall: in_valid with lane in_sel full and not ready gives in_ready = 0. The producer holds in_data and in_sel.
- in_valid = 0: no state change except drains. in_sel/in_data are don't-care.
- idle = ~|full (combinational from the registers).
- Unknown select bits: none exist; the 3-bit select covers all 8 lanes.

Test Plan:
- Reset: assert rst mid-cycle with lanes 2 and 5 full → out_valid = 8'h00 immediately, idle = 1, in_ready = 1; after release, the first accept goes to lane 0 on the next edge.
- Routing sweep: out_ready = 8'hFF; send in_sel = 0..7 with in_data = 64'h1000+sel, one per cycle → each lane i shows out_valid[i] one cycle later with data 64'h1000+i; in_ready stays 1.
- Backpressure: out_ready[3] = 0; send 64'hAAAA then 64'hBBBB to lane 3 → first is accepted; second sees in_ready = 0 and lane 3 holds 64'hAAAA. Raise out_ready[3] → 64'hAAAA drains and 64'hBBBB is accepted on the same edge, then appears the next cycle.
- Isolation: lane 3 full and stalled; send 64'hCCCC to lane 6 → in_ready = 1 and lane 6 receives it; lane 3 is unchanged.
- Streaming: lane 1 with out_ready[1] = 1 and 16 back-to-back words 0..15 → one word per cycle, in order, with no bubbles after the first cycle.
- Idle: fill lanes 0 and 7 with out_ready = 0, then release them one at a time → idle goes 0, stays 0 after the first drain, and returns to 1 after the second drain.
